// File: rtl/icache_axi_rd_bridge.sv
// rtl/icache_axi_rd_bridge.sv - instruction-cache read bridge onto a single-ID AXI read channel
// One transaction in flight: an 8-beat INCR burst for a cache line, or a single beat for an uncached word.
module icache_axi_rd_bridge #(
    parameter logic [3:0] ARID_VAL = 4'h0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic         rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [255:0] ret_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic         rd_err
);

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           type_q;
    logic [31:0]    addr_q;
    logic [255:0]   line_q;
    logic [2:0]     beat_cnt;
    logic [7:0]     beat_lsb;
    logic           err_q;
    logic           accept;
    logic           beat_ok;
    logic           final_beat;

    assign accept     = rd_req && (state == IDLE);
    // Beats carrying a foreign ID are still handshaken but never counted or stored.
    assign beat_ok    = rvalid && (state == R) && (rid == ARID_VAL);
    assign final_beat = type_q ? (beat_cnt == 3'd7) : (beat_cnt == 3'd0);
    assign beat_lsb   = {beat_cnt, 5'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_rdy    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        case (state)
            IDLE: begin
                rd_rdy = 1'b1;
                if (rd_req) state_nxt = AR;
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = R;
            end
            R: begin
                rready = 1'b1;
                if (beat_ok && final_beat) state_nxt = RESP;
            end
            RESP: begin
                ret_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q   <= 1'b0;
            addr_q   <= 32'h0;
            line_q   <= 256'h0;
            beat_cnt <= 3'd0;
            err_q    <= 1'b0;
        end else if (accept) begin
            type_q   <= rd_type;
            addr_q   <= rd_addr;
            line_q   <= 256'h0;
            beat_cnt <= 3'd0;
        end else if (beat_ok) begin
            line_q[beat_lsb +: 32] <= rdata;
            beat_cnt               <= beat_cnt + 3'd1;
            // An early rlast is only flagged; the burst still runs to its counted length.
            if ((rlast != final_beat) || (rresp != 2'b00)) err_q <= 1'b1;
        end
    end

    assign araddr   = (state != AR) ? 32'h0 : (type_q ? {addr_q[31:5], 5'b0} : addr_q);
    assign arlen    = ((state == AR) && type_q) ? 8'd7 : 8'd0;
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign arid     = ARID_VAL;
    assign ret_data = (state == RESP) ? line_q : 256'h0;
    assign rd_err   = err_q;

endmodule

// File: doc/icache_axi_rd_bridge.md
ICACHE_AXI_RD_BRIDGE -- requirements
Module: icache_axi_rd_bridge

Interface
REQ-001 SHALL have parameter ARID_VAL, default 4'h0, the AXI ID driven on arid and matched on rid.
REQ-002 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have rd_req  input  1  cache read request.
REQ-005 SHALL have rd_type  input  1  1 = 32-byte cache line, 0 = single uncached word.
REQ-006 SHALL have rd_addr  input  32  request byte address.
REQ-007 SHALL have rd_rdy  output  1  bridge accepts a request this cycle.
REQ-008 SHALL have ret_valid  output  1  one-cycle return strobe.
REQ-009 SHALL have ret_data  output  256  returned data; word k in bits [32k+31:32k].
REQ-010 SHALL have arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 as outputs and arready 1 as input (AXI AR channel).
REQ-011 SHALL have rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 as inputs and rready 1 as output (AXI R channel).
REQ-012 SHALL have rd_err  output  1  sticky error flag.

Function
REQ-013 SHALL implement states IDLE, AR, R, RESP; reset state IDLE.
REQ-014 rd_rdy SHALL be 1 only in IDLE; a request is accepted when rd_req && rd_rdy.
REQ-015 On acceptance SHALL latch rd_type and rd_addr, clear the 256-bit line buffer and the 3-bit beat counter, and go to AR.
REQ-016 In AR: arvalid=1; araddr = {addr[31:5],5'b0} for line, addr unchanged for uncached; arlen = 7 (line) / 0 (uncached); arsize=3'b010; arburst=2'b01; arid=ARID_VAL.
REQ-017 AR channel outputs SHALL remain stable while arvalid && !arready; on arready go to R next cycle.
REQ-018 In R: rready=1; a beat is consumed when rvalid && rready.
REQ-019 A consumed beat with rid==ARID_VAL SHALL write rdata into buffer word[beat_cnt] and increment beat_cnt; beats with other rid SHALL be consumed and dropped without counting.
REQ-020 Final beat = counted beat with beat_cnt==7 (line) or beat_cnt==0 (uncached); after the final beat SHALL go to RESP regardless of rlast.
REQ-021 rlast mismatch (rlast=1 on a non-final counted beat, or rlast=0 on the final beat) SHALL set rd_err; an early rlast does not end the transfer.
REQ-022 Any counted beat with rresp!=2'b00 SHALL set rd_err; data is still stored and returned.
REQ-023 In RESP: ret_valid=1 for exactly one cycle with ret_data = buffer, then IDLE.
REQ-024 Uncached return SHALL carry the word in ret_data[31:0] with bits [255:32] zero.
REQ-025 ret_data SHALL be 0 whenever ret_valid=0.
REQ-026 Minimum latency, zero-wait slave: accept at cycle 0, arvalid at 1, beats 2..9, ret_valid at 10 (line); uncached ret_valid at 3.
REQ-027 Only one transaction in flight; rd_req outside IDLE SHALL be ignored (rd_rdy=0).
REQ-028 arvalid SHALL be 0 outside AR; rready SHALL be 0 outside R.

Reset
REQ-029 Reset SHALL asynchronously force IDLE, rd_rdy=1, ret_valid=0, ret_data=0, arvalid=0, rready=0, araddr=0, arlen=0, rd_err=0, buffer and beat_cnt cleared.
REQ-030 Reset mid-transfer SHALL abandon the transfer; no ret_valid is produced for it.
REQ-031 rd_err SHALL be cleared only by reset.

Verification
REQ-032 Line read rd_addr=0x1FC0_0014, arready and rvalid always 1, rdata=0x100+k per beat -> araddr=0x1FC0_0000, arlen=7, ret_valid at cycle 10, ret_data word k = 0x100+k, rd_err=0.
REQ-033 Uncached read rd_addr=0xBFAF_F004, rdata=0xDEAD_BEEF, rlast=1 -> araddr=0xBFAF_F004, arlen=0, ret_data=0x...0_DEADBEEF (upper 224 bits zero), ret_valid at cycle 3.
REQ-034 arready held 0 for 5 cycles, rvalid toggling every other cycle -> AR signals stable while stalled, ret_valid after 8 counted beats, data in order.
REQ-035 Line read with rresp=2'b10 on beat 3 and rlast on beat 5 -> rd_err=1, transfer still completes after 8 beats, rd_err stays 1 until reset.
REQ-036 Beat with rid!=ARID_VAL inserted mid-burst -> dropped, beat_cnt unchanged, returned line identical to REQ-032.
REQ-037 Reset asserted during beat 4 -> immediately IDLE, rd_rdy=1, rready=0, no ret_valid; next request completes normally.
